// File: rtl/riscv_timer_tick_gen.sv
// Fractional clock divider producing single-cycle ticks for the RISC-V machine timer.
// Divisor, enable/restart and a running tick count are exposed over a 32-bit APB slave.
module riscv_timer_tick_gen #(
    parameter logic [15:0] RESET_DIV_INT  = 16'd12,
    parameter logic [7:0]  RESET_DIV_FRAC = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tick,
    output logic        tick_nrz
);

    localparam int unsigned CTR_W  = 17;
    localparam int unsigned INT_W  = 16;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned CNT_W  = 32;

    localparam logic [15:0] ADDR_CTRL    = 16'h0000;
    localparam logic [15:0] ADDR_DIV     = 16'h0004;
    localparam logic [15:0] ADDR_TICKCNT = 16'h0008;

    localparam logic [CTR_W-1:0] RESET_CTR =
        (RESET_DIV_INT < 16'd2) ? CTR_W'(1) : CTR_W'(RESET_DIV_INT);

    logic               en, en_d;
    logic [INT_W-1:0]   div_int, div_int_d;
    logic [FRAC_W-1:0]  div_frac, div_frac_d;
    logic [CNT_W-1:0]   tickcnt, tickcnt_d;
    logic [CTR_W-1:0]   ctr, ctr_d;
    logic [FRAC_W-1:0]  acc, acc_d;
    logic               tick_d, nrz_d;

    logic               bus_wr, wr_ctrl, wr_div, wr_cnt, restart;
    logic [CTR_W-1:0]   eff_int;
    logic [FRAC_W:0]    acc_sum;

    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    assign bus_wr  = psel && penable && pwrite;
    assign wr_ctrl = bus_wr && (paddr == ADDR_CTRL);
    assign wr_div  = bus_wr && (paddr == ADDR_DIV);
    assign wr_cnt  = bus_wr && (paddr == ADDR_TICKCNT);
    assign restart = wr_ctrl && pwdata[1];

    // Divisors below 2 collapse to 1 so the counter never needs to reach 0.
    assign eff_int = (div_int < INT_W'(2)) ? CTR_W'(1) : CTR_W'(div_int);
    assign acc_sum = {1'b0, acc} + {1'b0, div_frac};

    // Next-state: divider/accumulator first, then bus writes which override same-edge updates.
    always_comb begin
        en_d       = en;
        div_int_d  = div_int;
        div_frac_d = div_frac;
        tickcnt_d  = tickcnt;
        ctr_d      = ctr;
        acc_d      = acc;
        tick_d     = 1'b0;
        nrz_d      = tick_nrz;

        if (restart) begin
            ctr_d = eff_int;
            acc_d = '0;
        end else if (en) begin
            if (ctr == CTR_W'(1)) begin
                tick_d    = 1'b1;
                nrz_d     = ~tick_nrz;
                acc_d     = acc_sum[FRAC_W-1:0];
                ctr_d     = eff_int + CTR_W'(acc_sum[FRAC_W]);
                tickcnt_d = tickcnt + CNT_W'(1);
            end else begin
                ctr_d = ctr - CTR_W'(1);
            end
        end

        if (wr_ctrl) begin
            en_d = pwdata[0];
        end
        if (wr_div) begin
            div_int_d  = pwdata[15:0];
            div_frac_d = pwdata[23:16];
        end
        if (wr_cnt) begin
            tickcnt_d = pwdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b1;
            div_int  <= RESET_DIV_INT;
            div_frac <= RESET_DIV_FRAC;
            tickcnt  <= '0;
            ctr      <= RESET_CTR;
            acc      <= '0;
            tick     <= 1'b0;
            tick_nrz <= 1'b0;
        end else begin
            en       <= en_d;
            div_int  <= div_int_d;
            div_frac <= div_frac_d;
            tickcnt  <= tickcnt_d;
            ctr      <= ctr_d;
            acc      <= acc_d;
            tick     <= tick_d;
            tick_nrz <= nrz_d;
        end
    end

    // Side-effect-free register readback.
    always_comb begin
        prdata = '0;
        case (paddr)
            ADDR_CTRL:    prdata = {31'b0, en};
            ADDR_DIV:     prdata = {8'b0, div_frac, div_int};
            ADDR_TICKCNT: prdata = tickcnt;
            default:      prdata = '0;
        endcase
    end

endmodule
